// File: rtl/dsp_pkg.sv
// ============================================================================
//  Module      : dsp_pkg
//  Description : Shared operand width, counter width and FSM state encodings
//                for the square / sqrt-family arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_pkg;

   localparam int W     = 17;
   localparam int CNT_W = 5;

   // Index of the final shift-add step; the FSM leaves sop on this count.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SOP    = 2'd1,
      ST_DONE   = 2'd2,
      ST_UNUSED = 2'd3
   } state_e;

endpackage : dsp_pkg

`default_nettype wire

// File: rtl/square.sv
// ============================================================================
//  Module      : square
//  Description : Sequential unsigned squarer, one radix-2 shift-add step per
//                clock; fixed W+1 cycle latency from accept to result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module square
   import dsp_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     x_in,
   input  logic             start,
   output logic [2*W-1:0]   f_out,
   output logic             valid,
   output logic             busy,
   output logic [CNT_W-1:0] count_o,
   output logic [1:0]       s_o
);

   state_e             state_q,  state_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [W-1:0]       mcand_q,  mcand_d;
   logic [W-1:0]       mplier_q, mplier_d;
   logic [2*W-1:0]     acc_q,    acc_d;
   logic [2*W-1:0]     f_out_q,  f_out_d;
   logic               valid_q,  valid_d;
   logic               busy_q,   busy_d;

   logic [2*W-1:0]     w_addend;

   // Partial product for the current multiplier bit; the sum of all partials
   // is at most (2^W-1)^2, so the 2W-bit accumulator never wraps.
   assign w_addend = {{W{1'b0}}, mcand_q} << count_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      f_out_d  = f_out_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_SOP;
               mcand_d  = x_in;
               mplier_d = x_in;
               acc_d    = '0;
               count_d  = '0;
               busy_d   = 1'b1;
            end
         end
         ST_SOP: begin
            if (mplier_q[count_q]) begin
               acc_d = acc_q + w_addend;
            end
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            f_out_d = acc_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         f_out_q  <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         f_out_q  <= f_out_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
      end
   end

   assign f_out   = f_out_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign count_o = count_q;
   assign s_o     = state_q;

endmodule : square

`default_nettype wire

// File: doc/square.md
SQUARE -- requirements
Module: square

Interface
REQ-001 W, 17, operand width in bits; the result width is 2*W.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 x_in  input  W  unsigned operand, sampled only on the accepting edge.
REQ-005 start  input  1  request; accepted only when the FSM is in state idle.
REQ-006 f_out  output  2*W  registered result x_in*x_in; holds its value until the next completion.
REQ-007 valid  output  1  one-cycle strobe; high in the cycle after f_out is updated.
REQ-008 busy  output  1  high from the accepting edge until the completion edge.
REQ-009 count_o  output  5  test output: current iteration index.
REQ-010 s_o  output  2  test output: current FSM state.

Function
REQ-011 The FSM SHALL have four states, with these encodings and transitions:
- idle=0: goes to sop when start=1.
- sop=1: stays in sop while count<W-1; goes to done when count=W-1.
- done=2: always goes to idle.
- state 3: unused; goes to idle.
REQ-012 The accepting edge (idle with start=1) SHALL capture x_in into both the multiplicand register and the multiplier register, and SHALL clear the accumulator and count.
REQ-013 Each sop edge SHALL perform one radix-2 shift-add step:
- if multiplier bit[count]=1, acc <= acc + (multiplicand << count);
- count <= count+1.
REQ-014 The accumulator SHALL be 2*W bits wide, and no step SHALL overflow it.
REQ-015 The done edge SHALL load f_out <= acc and set valid=1; the next edge SHALL clear valid.
REQ-016 Latency SHALL be fixed:
- accepting edge n;
- sop edges n+1 .. n+W;
- done edge n+W+1 (n+18 for W=17).
REQ-017 busy SHALL be set on the accepting edge and cleared on the done edge.
REQ-018 start SHALL be ignored while busy=1: no restart, and no corruption of the operand registers.
REQ-019 With start held high continuously, a new operation SHALL be accepted every W+2 edges (19).
REQ-020 x_in SHALL NOT affect an operation in progress after the accepting edge.
REQ-021 count_o SHALL equal count and s_o SHALL equal the state register, both registered.

Reset
REQ-022 When reset=1 at a rising edge, the block SHALL clear the following, regardless of state:
- state to idle;
- count, acc, the operand registers, f_out, valid and busy to 0.
REQ-023 A reset during sop SHALL abort the operation; no valid strobe SHALL follow.
REQ-024 reset SHALL take priority over a simultaneous start.
REQ-025 The first edge after reset deasserts SHALL be able to accept a start.

Structure
REQ-026 The state encodings (idle, sop, done) and W SHALL be defined in a shared package, dsp_pkg, which the sqrt-family blocks reuse.
REQ-027 The block SHALL be a single module containing the FSM and the shift-add datapath, with no sub-modules.

Verification
REQ-028 x_in=0, start pulse at edge n -> valid at n+18, f_out=0.
REQ-029 x_in=256 -> f_out=65536; x_in=1 -> f_out=1.
REQ-030 x_in=131071 -> f_out=17179607041; x_in=46341 -> f_out=2147488281.
REQ-031 start=1 with x_in=3, then start pulsed again at n+5 with x_in=7 -> only one valid, f_out=9, busy continuously high from n to n+18.
REQ-032 reset at n+6 of an operation -> busy=0, valid=0, f_out=0, s_o=0; a fresh start with x_in=5 -> f_out=25 after 18 cycles.
REQ-033 start held high, x_in=2 then 10 -> valid at n+18 (f_out=4) and at n+37 (f_out=100), i.e. a period of 19 edges.
